bus_arbiter_rr: RTL and testbench

Multi-channel external bus arbiter and sequencer for micro-BESM. NCH requesters share one busio port and memory bus. A round-robin grant selects one requester, latches its opcode, and runs the address, strobe and data phases. Wait states come from the bus `rdy` input, bursts run without re-sending the address, and a wait-state timeout aborts the transaction with an error.

---
 rtl/bus_arbiter_rr.sv | 269 ++++++++++++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter and bus sequencer for the micro-BESM
// external bus. One granted channel at a time runs its address, setup,
// wait and acknowledge phases over the shared busio port. Wait states come
// from rdy, bursts skip the address phase, and a wait-state timeout aborts.
module bus_arbiter_rr #(
  parameter int NCH     = 2,
  parameter int BURST_W = 3,
  parameter int TMO_W   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         req,
  input  logic [4*NCH-1:0]       op,
  input  logic [BURST_W*NCH-1:0] len,
  input  logic                   suspend,
  input  logic                   rdy,
  output logic [NCH-1:0]         gnt,
  output logic [1:0]             arx,
  output logic                   ecx,
  output logic                   wrx,
  output logic                   astb,
  output logic                   rd,
  output logic                   wr,
  output logic                   iack,
  output logic [NCH-1:0]         done,
  output logic [NCH-1:0]         fin,
  output logic                   err
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [3:0] OP_FETCH = 4'd8;
  localparam logic [3:0] OP_DRD   = 4'd9;
  localparam logic [3:0] OP_DWR   = 4'd10;
  localparam logic [3:0] OP_RDMWR = 4'd11;
  localparam logic [3:0] OP_BTRWR = 4'd12;
  localparam logic [3:0] OP_BTRRD = 4'd13;
  localparam logic [3:0] OP_BIRD  = 4'd15;

  localparam logic [1:0] ARX_ADDR  = 2'd0;
  localparam logic [1:0] ARX_CMD   = 2'd1;
  localparam logic [1:0] ARX_RDATA = 2'd2;
  localparam logic [1:0] ARX_WDATA = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_SETUP = 3'd2,
    ST_WAIT  = 3'd3,
    ST_ACK   = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  // Opcodes the sequencer knows how to run; anything else is aborted.
  function automatic logic op_valid(input logic [3:0] o);
    return ((o >= OP_FETCH) && (o <= OP_BTRRD)) || (o == OP_BIRD);
  endfunction

  // Write opcodes need a SETUP phase before every data strobe.
  function automatic logic op_is_write(input logic [3:0] o);
    return (o == OP_DWR) || (o == OP_BTRWR);
  endfunction

  // First requesting channel strictly after 'last' in circular order.
  // Returns {hit, index}; the loop runs lowest priority first so the
  // nearest requester overwrites any farther one.
  function automatic logic [IDX_W:0] rr_pick(input logic [NCH-1:0] r,
                                             input logic [IDX_W-1:0] last);
    logic [IDX_W:0] res;
    int c;
    res = '0;
    for (int k = NCH; k >= 1; k--) begin
      c   = (int'(last) + k) % NCH;
      res = r[c] ? {1'b1, IDX_W'(c)} : res;
    end
    return res;
  endfunction

  state_t               state_r, state_nx_s;
  logic [3:0]           op_r, op_nx_s;
  logic [BURST_W-1:0]   wcnt_r, wcnt_nx_s;
  logic [TMO_W-1:0]     tmo_r, tmo_nx_s;
  logic [NCH-1:0]       gnt_r, gnt_nx_s;
  logic [IDX_W-1:0]     last_r, last_nx_s;

  logic [IDX_W:0]       pick_s;
  logic [IDX_W-1:0]     pick_idx_s;
  logic                 pick_hit_s;
  logic [3:0]           op_sel_s;
  logic [BURST_W-1:0]   len_sel_s;
  logic                 hold_s;

  logic [1:0]           arx_s;
  logic                 ecx_s, wrx_s, astb_s, rd_s, wr_s, iack_s;
  logic                 done_s, fin_s, err_s;

  assign pick_s     = rr_pick(req, last_r);
  assign pick_idx_s = pick_s[IDX_W-1:0];
  assign pick_hit_s = pick_s[IDX_W];
  assign op_sel_s   = op[4*int'(pick_idx_s) +: 4];
  assign len_sel_s  = len[BURST_W*int'(pick_idx_s) +: BURST_W];
  assign hold_s     = suspend && (state_r != ST_IDLE);

  // State, latched transaction context and arbitration pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      op_r    <= 4'd0;
      wcnt_r  <= '0;
      tmo_r   <= '0;
      gnt_r   <= '0;
      last_r  <= IDX_W'(NCH - 1);
    end else begin
      state_r <= state_nx_s;
      op_r    <= op_nx_s;
      wcnt_r  <= wcnt_nx_s;
      tmo_r   <= tmo_nx_s;
      gnt_r   <= gnt_nx_s;
      last_r  <= last_nx_s;
    end
  end

  // Next-state logic: arbitration in IDLE, phase sequencing elsewhere.
  // A suspended transaction keeps every register as it is.
  always_comb begin
    state_nx_s = state_r;
    op_nx_s    = op_r;
    wcnt_nx_s  = wcnt_r;
    tmo_nx_s   = tmo_r;
    gnt_nx_s   = gnt_r;
    last_nx_s  = last_r;
    if (hold_s) begin
      state_nx_s = state_r;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!suspend && pick_hit_s) begin
            gnt_nx_s  = {{(NCH-1){1'b0}}, 1'b1} << pick_idx_s;
            last_nx_s = pick_idx_s;
            op_nx_s   = op_sel_s;
            wcnt_nx_s = ((op_sel_s == OP_BTRWR) || (op_sel_s == OP_BTRRD)) ? len_sel_s : '0;
            tmo_nx_s  = '0;
            if (!op_valid(op_sel_s)) begin
              state_nx_s = ST_ABORT;
            end else if (op_sel_s == OP_BIRD) begin
              state_nx_s = ST_WAIT;
            end else begin
              state_nx_s = ST_ADDR;
            end
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_ADDR: begin
          tmo_nx_s   = '0;
          state_nx_s = op_is_write(op_r) ? ST_SETUP : ST_WAIT;
        end
        ST_SETUP: begin
          tmo_nx_s   = '0;
          state_nx_s = ST_WAIT;
        end
        ST_WAIT: begin
          if (rdy) begin
            state_nx_s = ST_ACK;
          end else if (&tmo_r) begin
            state_nx_s = ST_ABORT;
          end else begin
            tmo_nx_s = tmo_r + TMO_W'(1);
          end
        end
        ST_ACK: begin
          if (wcnt_r != '0) begin
            wcnt_nx_s  = wcnt_r - BURST_W'(1);
            tmo_nx_s   = '0;
            state_nx_s = op_is_write(op_r) ? ST_SETUP : ST_WAIT;
          end else begin
            gnt_nx_s   = '0;
            state_nx_s = ST_IDLE;
          end
        end
        ST_ABORT: begin
          gnt_nx_s   = '0;
          state_nx_s = ST_IDLE;
        end
        default: begin
          gnt_nx_s   = '0;
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Bus controls decoded from the current phase and the latched opcode.
  always_comb begin
    arx_s  = ARX_RDATA;
    ecx_s  = 1'b0;
    wrx_s  = 1'b0;
    astb_s = 1'b0;
    rd_s   = 1'b0;
    wr_s   = 1'b0;
    iack_s = 1'b0;
    done_s = 1'b0;
    fin_s  = 1'b0;
    err_s  = 1'b0;
    case (state_r)
      ST_ADDR: begin
        arx_s  = ARX_ADDR;
        ecx_s  = 1'b1;
        astb_s = 1'b1;
      end
      ST_SETUP: begin
        arx_s = ARX_WDATA;
        ecx_s = 1'b1;
      end
      ST_WAIT: begin
        ecx_s = 1'b1;
        case (op_r)
          OP_FETCH: begin
            arx_s = ARX_CMD;
            rd_s  = 1'b1;
          end
          OP_DRD, OP_RDMWR, OP_BTRRD: rd_s = 1'b1;
          OP_DWR, OP_BTRWR: begin
            arx_s = ARX_WDATA;
            wr_s  = 1'b1;
          end
          OP_BIRD: iack_s = 1'b1;
          default: ecx_s = 1'b1;
        endcase
      end
      ST_ACK: begin
        ecx_s  = 1'b1;
        done_s = 1'b1;
        fin_s  = (wcnt_r == '0);
        case (op_r)
          OP_FETCH: begin
            arx_s = ARX_CMD;
            wrx_s = 1'b1;
          end
          OP_DRD, OP_RDMWR, OP_BTRRD: wrx_s = 1'b1;
          OP_BIRD: begin
            wrx_s  = 1'b1;
            iack_s = 1'b1;
          end
          default: wrx_s = 1'b0;
        endcase
      end
      ST_ABORT: begin
        err_s = 1'b1;
        fin_s = 1'b1;
      end
      default: arx_s = ARX_RDATA;
    endcase
  end

  // While suspended every strobe and pulse is forced low.
  assign gnt  = gnt_r;
  assign arx  = arx_s;
  assign ecx  = ecx_s  & ~hold_s;
  assign wrx  = wrx_s  & ~hold_s;
  assign astb = astb_s & ~hold_s;
  assign rd   = rd_s   & ~hold_s;
  assign wr   = wr_s   & ~hold_s;
  assign iack = iack_s & ~hold_s;
  assign err  = err_s  & ~hold_s;
  assign done = (done_s && !hold_s) ? gnt_r : '0;
  assign fin  = (fin_s  && !hold_s) ? gnt_r : '0;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Testbench for bus_arbiter_rr (NCH=2, BURST_W=3, TMO_W=4). Each scenario
// queues per-cycle stimulus with its hand-derived expected outputs; the
// expected word is pushed to the scoreboard when the stimulus is driven and
// popped and compared against the DUT one time step later in the same cycle.
module tb_bus_arbiter_rr;

  localparam logic [5:0] S_0   = 6'b000000; // {ecx,wrx,astb,rd,wr,iack}
  localparam logic [5:0] S_E   = 6'b100000;
  localparam logic [5:0] S_EA  = 6'b101000;
  localparam logic [5:0] S_ER  = 6'b100100;
  localparam logic [5:0] S_EW  = 6'b100010;
  localparam logic [5:0] S_EWX = 6'b110000;
  localparam logic [5:0] S_EI  = 6'b100001;
  localparam logic [5:0] S_EWI = 6'b110001;
  localparam logic [1:0] A_AD  = 2'd0;
  localparam logic [1:0] A_RD  = 2'd2;
  localparam logic [1:0] A_WD  = 2'd3;

  typedef struct packed {
    logic [1:0]  req;
    logic        rdy;
    logic        susp;
    logic        rst;
    logic [14:0] exp;
  } step_t;

  logic        clk, reset, suspend, rdy;
  logic [1:0]  req;
  logic [7:0]  op;
  logic [5:0]  len;
  logic [1:0]  gnt, arx, done, fin;
  logic        ecx, wrx, astb, rd, wr, iack, err;
  logic [14:0] obs;

  step_t       plan_q[$];
  logic [14:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;

  assign obs = {gnt, arx, ecx, wrx, astb, rd, wr, iack, done, fin, err};

  bus_arbiter_rr #(.NCH(2), .BURST_W(3), .TMO_W(4)) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .len(len),
    .suspend(suspend), .rdy(rdy), .gnt(gnt), .arx(arx), .ecx(ecx),
    .wrx(wrx), .astb(astb), .rd(rd), .wr(wr), .iack(iack),
    .done(done), .fin(fin), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t mk(input logic [1:0] rq, input logic ry, input logic su,
                               input logic rs, input logic [1:0] g, input logic [1:0] ax,
                               input logic [5:0] stb, input logic [1:0] dn,
                               input logic [1:0] fn, input logic er);
    step_t t;
    t.req  = rq;
    t.rdy  = ry;
    t.susp = su;
    t.rst  = rs;
    t.exp  = {g, ax, stb, dn, fn, er};
    return t;
  endfunction

  function automatic step_t idle(input logic [1:0] rq, input logic ry, input logic rs);
    return mk(rq, ry, 1'b0, rs, 2'b00, A_RD, S_0, 2'b00, 2'b00, 1'b0);
  endfunction

  task automatic test_reset();
    step_t st; logic [14:0] e; int n = 0;
    plan_q.push_back(idle(2'b00, 1'b1, 1'b1));
    plan_q.push_back(idle(2'b00, 1'b1, 1'b1));
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req = st.req; rdy = st.rdy; suspend = st.susp; reset = st.rst;
      sb_q.push_back(st.exp);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_single_read();
    step_t st; logic [14:0] e; int n = 0;
    op = 8'h09; len = 6'd0;
    plan_q.push_back(idle(2'b01, 1'b1, 1'b0));
    plan_q.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, A_AD, S_EA, 2'b00, 2'b00, 1'b0));
    plan_q.push_back(mk(2'b01, 1'b1, 1'b0, 1'b0, 2'b01, A_RD, S_ER, 2'b00, 2'b00, 1'b0));
    plan_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b01, A_RD, S_EWX, 2'b01, 2'b01, 1'b0));
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req = st.req; rdy = st.rdy; suspend = st.susp; reset = st.rst;
      sb_q.push_back(st.exp);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_read step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    step_t st; logic [14:0] e; logic [1:0] g; int n = 0;
    op = 8'hAA; len = 6'd0;
    plan_q.push_back(idle(2'b00, 1'b1, 1'b1));
    for (int t = 0; t < 4; t++) begin
      g = (t % 2 == 0) ? 2'b01 : 2'b10;
      plan_q.push_back(idle(2'b11, 1'b1, 1'b0));
      plan_q.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, g, A_AD, S_EA, 2'b00, 2'b00, 1'b0));
      plan_q.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, g, A_WD, S_E, 2'b00, 2'b00, 1'b0));
      plan_q.push_back(mk(2'b11, 1'b1, 1'b0, 1'b0, g, A_WD, S_EW, 2'b00, 2'b00, 1'b0));
      plan_q.push_back(mk((t == 3) ? 2'b00 : 2'b11, 1'b1, 1'b0, 1'b0, g, A_RD, S_E, g, g, 1'b0));
    end
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req = st.req; rdy = st.rdy; suspend = st.susp; reset = st.rst;
      sb_q.push_back(st.exp);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_burst_read();
    step_t st; logic [14:0] e; int n = 0;
    op = 8'hD0; len = 6'b011_000;
    plan_q.push_back(idle(2'b10, 1'b1, 1'b0));
    plan_q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, A_AD, S_EA, 2'b00, 2'b00, 1'b0));
    for (int w = 0; w < 4; w++) begin
      plan_q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, A_RD, S_ER, 2'b00, 2'b00, 1'b0));
      plan_q.push_back(mk((w == 3) ? 2'b00 : 2'b10, 1'b1, 1'b0, 1'b0, 2'b10, A_RD, S_EWX,
                          2'b10, (w == 3) ? 2'b10 : 2'b00, 1'b0));
    end
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req = st.req; rdy = st.rdy; suspend = st.susp; reset = st.rst;
      sb_q.push_back(st.exp);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL burst_read step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_wait_states();
    step_t st; logic [14:0] e; int n = 0;
    op = 8'h0A; len = 6'd0;
    plan_q.push_back(idle(2'b01, 1'b0, 1'b0));
    plan_q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b01, A_AD, S_EA, 2'b00, 2'b00, 1'b0));
    plan_q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b01, A_WD, S_E, 2'b00, 2'b00, 1'b0));
    for (int w = 0; w < 6; w++) begin
      plan_q.push_back(mk(2'b01, (w == 5) ? 1'b1 : 1'b0, 1'b0, 1'b0, 2'b01, A_WD, S_EW,
                          2'b00, 2'b00, 1'b0));
    end
    plan_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b01, A_RD, S_E, 2'b01, 2'b01, 1'b0));
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req = st.req; rdy = st.rdy; suspend = st.susp; reset = st.rst;
      sb_q.push_back(st.exp);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL wait_states step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_timeout();
    step_t st; logic [14:0] e; int n = 0;
    op = 8'h09; len = 6'd0;
    plan_q.push_back(idle(2'b01, 1'b0, 1'b0));
    plan_q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b01, A_AD, S_EA, 2'b00, 2'b00, 1'b0));
    for (int w = 0; w < 16; w++) begin
      plan_q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b01, A_RD, S_ER, 2'b00, 2'b00, 1'b0));
    end
    plan_q.push_back(mk(2'b00, 1'b0, 1'b0, 1'b0, 2'b01, A_RD, S_0, 2'b00, 2'b01, 1'b1));
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req = st.req; rdy = st.rdy; suspend = st.susp; reset = st.rst;
      sb_q.push_back(st.exp);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timeout step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_suspend();
    step_t st; logic [14:0] e; int n = 0;
    op = 8'hC0; len = 6'b001_000;
    plan_q.push_back(idle(2'b10, 1'b1, 1'b0));
    plan_q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, A_AD, S_EA, 2'b00, 2'b00, 1'b0));
    plan_q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, A_WD, S_E, 2'b00, 2'b00, 1'b0));
    for (int w = 0; w < 3; w++) begin
      plan_q.push_back(mk(2'b10, 1'b1, 1'b1, 1'b0, 2'b10, A_WD, S_0, 2'b00, 2'b00, 1'b0));
    end
    plan_q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, A_WD, S_EW, 2'b00, 2'b00, 1'b0));
    plan_q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, A_RD, S_E, 2'b10, 2'b00, 1'b0));
    plan_q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, A_WD, S_E, 2'b00, 2'b00, 1'b0));
    plan_q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, A_WD, S_EW, 2'b00, 2'b00, 1'b0));
    plan_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b10, A_RD, S_E, 2'b10, 2'b10, 1'b0));
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req = st.req; rdy = st.rdy; suspend = st.susp; reset = st.rst;
      sb_q.push_back(st.exp);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL suspend step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_abort_and_reset();
    step_t st; logic [14:0] e; int n = 0;
    op = 8'h0E; len = 6'd0;
    plan_q.push_back(idle(2'b01, 1'b1, 1'b0));
    plan_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b01, A_RD, S_0, 2'b00, 2'b01, 1'b1));
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req = st.req; rdy = st.rdy; suspend = st.susp; reset = st.rst;
      sb_q.push_back(st.exp);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL bad_opcode step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
    op = 8'h09;
    n  = 0;
    plan_q.push_back(idle(2'b01, 1'b0, 1'b0));
    plan_q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b0, 2'b01, A_AD, S_EA, 2'b00, 2'b00, 1'b0));
    plan_q.push_back(mk(2'b01, 1'b0, 1'b0, 1'b1, 2'b01, A_RD, S_ER, 2'b00, 2'b00, 1'b0));
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req = st.req; rdy = st.rdy; suspend = st.susp; reset = st.rst;
      sb_q.push_back(st.exp);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset_mid_wait step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  task automatic test_bird();
    step_t st; logic [14:0] e; int n = 0;
    op = 8'hF0; len = 6'd0;
    plan_q.push_back(idle(2'b10, 1'b1, 1'b0));
    plan_q.push_back(mk(2'b10, 1'b1, 1'b0, 1'b0, 2'b10, A_RD, S_EI, 2'b00, 2'b00, 1'b0));
    plan_q.push_back(mk(2'b00, 1'b1, 1'b0, 1'b0, 2'b10, A_RD, S_EWI, 2'b10, 2'b10, 1'b0));
    plan_q.push_back(idle(2'b00, 1'b1, 1'b0));
    while (plan_q.size() > 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req = st.req; rdy = st.rdy; suspend = st.susp; reset = st.rst;
      sb_q.push_back(st.exp);
      #1;
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL bird step %0d: got %b expected %b", n, obs, e);
      end
      n++;
    end
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    req     = 2'b00;
    op      = 8'h00;
    len     = 6'd0;
    rdy     = 1'b1;
    suspend = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_burst_read();
    test_wait_states();
    test_timeout();
    test_suspend();
    test_abort_and_reset();
    test_bird();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
